// File: rtl/pixel_io_responder.sv
// pixel_io_responder: memory-mapped display peripheral. Exposes CTRL/STATUS/FRAMES
// registers and a pixel frame buffer to CPU loads/stores. It scans the buffer out
// on a valid/ready pixel stream, either one frame per START or continuously.
module pixel_io_responder #(
    parameter logic [7:0] IO_SEL   = 8'h02,
    parameter int         FB_BASE  = 604,
    parameter int         FB_DEPTH = 600
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] mem_address,
    input  logic [63:0] mem_write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [63:0] mem_read_data,
    input  logic        link_up,
    output logic [63:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last
);

    localparam int IW = $clog2(FB_DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0]    state_r;
    logic [IW-1:0] idx_r;
    logic          cont_r;
    logic          done_r;
    logic [15:0]   frames_r;
    logic [63:0]   fb_r [FB_DEPTH];

    logic          hit_s;
    logic [55:0]   off_s;
    logic          in_fb_s;
    logic [IW-1:0] fb_idx_s;
    logic          ctrl_wr_s;
    logic          fb_wr_s;
    logic          beat_s;
    logic          eof_s;
    logic          start_s;
    logic [IW-1:0] idx_inc_s;
    logic [63:0]   rdata_s;

    assign hit_s     = (mem_address[63:56] == IO_SEL);
    assign off_s     = mem_address[55:0];
    assign in_fb_s   = (off_s >= 56'(FB_BASE)) && (off_s < 56'(FB_BASE + FB_DEPTH));
    assign fb_idx_s  = IW'(off_s - 56'(FB_BASE));
    assign ctrl_wr_s = mem_write && hit_s && (off_s == 56'd0);
    assign fb_wr_s   = mem_write && hit_s && in_fb_s;
    assign beat_s    = (state_r == ST_SCAN) && pix_valid && pix_ready;
    assign eof_s     = beat_s && (idx_r == IW'(FB_DEPTH - 1));
    // START only launches a frame from IDLE with a sink attached.
    assign start_s   = ctrl_wr_s && mem_write_data[0] && link_up && (state_r == ST_IDLE);
    assign idx_inc_s = idx_r + IW'(1);

    // Combinational load data: register file and frame buffer read mux.
    always_comb begin
        rdata_s = 64'd0;
        if (mem_read && hit_s) begin
            if (off_s == 56'd0) begin
                rdata_s = {61'd0, 1'b0, cont_r, 1'b0};
            end else if (off_s == 56'd2) begin
                rdata_s = {61'd0, done_r, (state_r == ST_IDLE), link_up};
            end else if (off_s == 56'd3) begin
                rdata_s = {48'd0, frames_r};
            end else if (in_fb_s) begin
                rdata_s = fb_r[fb_idx_s];
            end else begin
                rdata_s = 64'd0;
            end
        end else begin
            rdata_s = 64'd0;
        end
    end

    assign mem_read_data = rdata_s;

    // Frame buffer storage; contents survive reset by design.
    always_ff @(posedge clock) begin
        if (fb_wr_s) begin
            fb_r[fb_idx_s] <= mem_write_data;
        end
    end

    // Control registers, done flag and frame counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            cont_r   <= 1'b0;
            done_r   <= 1'b0;
            frames_r <= 16'd0;
        end else begin
            if (ctrl_wr_s) begin
                cont_r <= mem_write_data[1];
            end
            // End-of-frame set has priority over a coincident CLR_DONE.
            if (eof_s) begin
                done_r <= 1'b1;
            end else if (ctrl_wr_s && mem_write_data[2]) begin
                done_r <= 1'b0;
            end
            if (eof_s) begin
                frames_r <= frames_r + 16'd1;
            end
        end
    end

    // Scan-out FSM; pix_data is loaded from the buffer when a beat is set up,
    // so a store to the word currently on the link only shows on the next frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            pix_data  <= 64'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r   <= ST_SCAN;
                        idx_r     <= '0;
                        pix_valid <= 1'b1;
                        pix_data  <= fb_r[IW'(0)];
                        pix_last  <= (IW'(0) == IW'(FB_DEPTH - 1));
                    end
                end
                ST_SCAN: begin
                    if (eof_s) begin
                        if (cont_r) begin
                            idx_r    <= '0;
                            pix_data <= fb_r[IW'(0)];
                            pix_last <= (IW'(0) == IW'(FB_DEPTH - 1));
                        end else begin
                            state_r   <= ST_IDLE;
                            idx_r     <= '0;
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                        end
                    end else if (beat_s) begin
                        idx_r    <= idx_inc_s;
                        pix_data <= fb_r[idx_inc_s];
                        pix_last <= (idx_inc_s == IW'(FB_DEPTH - 1));
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    idx_r     <= '0;
                    pix_valid <= 1'b0;
                    pix_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_io_responder.sv
// Scoreboard bench for pixel_io_responder: stimulus pushes the expected beats of
// each frame from a reference copy of the frame buffer; a monitor pops and
// compares every accepted beat.
module tb_pixel_io_responder;

    localparam int DEPTH = 600;
    localparam int BASE  = 604;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_read_data;
    logic        link_up;
    logic [63:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;

    int total = 0;
    int bad = 0;
    int accepted = 0;
    int ready_mode = 3;
    int base;
    logic [64:0] sb [$];
    logic [63:0] fb_m [DEPTH];
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data = 64'd0;
    logic        saw_valid;
    logic [63:0] word;

    pixel_io_responder dut (
        .clock          (clock),
        .reset          (reset),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data),
        .link_up        (link_up),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_last       (pix_last)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] io(input int off);
        return {8'h02, 56'(off)};
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [63:0] addr, input logic [63:0] d);
        mem_address    = addr;
        mem_write_data = d;
        mem_write      = 1'b1;
        @(posedge clock);
        #1;
        mem_write = 1'b0;
    endtask

    task automatic rd(input logic [63:0] addr, input logic [63:0] exp, input string name);
        mem_address = addr;
        mem_read    = 1'b1;
        #2;
        check64(name, mem_read_data, exp);
        mem_read = 1'b0;
    endtask

    task automatic push_frame();
        for (int i = 0; i < DEPTH; i++) begin
            sb.push_back({(i == DEPTH - 1), fb_m[i]});
        end
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        while ((sb.size() != 0 || pix_valid === 1'b1) && n < limit) begin
            tick();
            n++;
        end
        total++;
        if (n >= limit) begin
            bad++;
            $display("FAIL %s: timeout after %0d cycles, %0d beats outstanding, required 0", name, n, sb.size());
        end
    endtask

    task automatic wait_beats(input int target, input int limit, input string name);
        int n;
        n = 0;
        while (accepted < target && n < limit) begin
            tick();
            n++;
        end
        total++;
        if (n >= limit) begin
            bad++;
            $display("FAIL %s: timeout, accepted %0d required %0d", name, accepted, target);
        end
    endtask

    // Ready pattern generator.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0: pix_ready = 1'b1;
                1: begin
                    cnt++;
                    if (cnt >= 3) begin
                        cnt = 0;
                        pix_ready = ~pix_ready;
                    end
                end
                2: pix_ready = 1'($urandom_range(0, 1));
                default: pix_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare accepted beats with the scoreboard, check hold while stalled.
    initial begin
        logic [64:0] exp;
        forever begin
            @(negedge clock);
            if (reset === 1'b0 && prev_stall) begin
                check64("stall_hold", {pix_valid, pix_data[62:0]}, {1'b1, prev_data[62:0]});
            end
            if (reset === 1'b0 && pix_valid === 1'b1 && pix_ready === 1'b1) begin
                accepted++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got data %h last %b, required no beat", pix_data, pix_last);
                end else begin
                    exp = sb.pop_front();
                    if ({pix_last, pix_data} !== exp) begin
                        bad++;
                        $display("FAIL beat %0d: got last %b data %h expected last %b data %h",
                                 accepted, pix_last, pix_data, exp[64], exp[63:0]);
                    end
                end
            end
            prev_stall = (reset === 1'b0) && (pix_valid === 1'b1) && (pix_ready === 1'b0);
            prev_data  = pix_data;
        end
    end

    initial begin
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = 64'd0;
        mem_write_data = 64'd0; link_up = 1'b1; pix_ready = 1'b0;
        repeat (3) tick();
        check64("rst_pix_valid", {63'd0, pix_valid}, 64'd0);
        check64("rst_pix_last", {63'd0, pix_last}, 64'd0);
        check64("rst_pix_data", pix_data, 64'd0);
        reset = 1'b0;
        tick();
        rd(io(2), 64'h3, "t1_status");
        rd(io(3), 64'h0, "t1_frames");
        rd(io(0), 64'h0, "t1_ctrl");

        // Single frame of a constant word, ready always high.
        for (int i = 0; i < DEPTH; i++) begin
            fb_m[i] = 64'hC0300CF03CCC54FC;
            wr(io(BASE + i), fb_m[i]);
        end
        rd(io(BASE + DEPTH - 1), 64'hC0300CF03CCC54FC, "fb_last_word");
        rd(io(BASE + DEPTH), 64'h0, "fb_past_end");
        rd(io(BASE - 1), 64'h0, "fb_before_start");
        ready_mode = 0;
        base = accepted;
        push_frame();
        wr(io(0), 64'h5);
        rd(io(2), 64'h1, "t2_status_busy");
        wait_drain("t2_drain", 2000);
        check64("t2_beats", 64'(accepted - base), 64'd600);
        rd(io(2), 64'h7, "t2_status_done");
        rd(io(3), 64'h1, "t2_frames");

        // Random words, ready toggling every 3 cycles.
        for (int i = 0; i < DEPTH; i++) begin
            fb_m[i] = {$urandom, $urandom};
            wr(io(BASE + i), fb_m[i]);
        end
        ready_mode = 1;
        base = accepted;
        push_frame();
        wr(io(0), 64'h1);
        wait_drain("t3_drain", 4000);
        check64("t3_beats", 64'(accepted - base), 64'd600);
        rd(io(3), 64'h2, "t3_frames");

        // Continuous mode: three back-to-back frames, stop requested in the third.
        ready_mode = 0;
        base = accepted;
        push_frame(); push_frame(); push_frame();
        wr(io(0), 64'h3);
        rd(io(0), 64'h2, "t4_ctrl_cont");
        wait_beats(base + 1200, 3000, "t4_wait1200");
        rd(io(3), 64'h4, "t4_frames_after_two");
        rd(io(2), 64'h5, "t4_status_running");
        wr(io(0), 64'h0);
        wait_drain("t4_drain", 2000);
        check64("t4_beats", 64'(accepted - base), 64'd1800);
        rd(io(3), 64'h5, "t4_frames_final");
        rd(io(2), 64'h7, "t4_status_idle");

        // Link down: START ignored, RO registers and unmapped space.
        link_up = 1'b0;
        wr(io(0), 64'h4);
        rd(io(2), 64'h2, "t5_clr_done");
        wr(io(0), 64'h1);
        saw_valid = 1'b0;
        repeat (20) begin
            tick();
            if (pix_valid !== 1'b0) saw_valid = 1'b1;
        end
        check64("t5_no_beats", {63'd0, saw_valid}, 64'd0);
        wr(io(2), 64'hFF);
        rd(io(2), 64'h2, "t5_status_ro");
        wr(io(3), 64'h1234);
        rd(io(3), 64'h5, "t5_frames_ro");
        wr(io(1), 64'hDEAD);
        rd(io(1), 64'h0, "t5_unmapped");
        word = {$urandom, $urandom};
        wr(io(700), word);
        fb_m[700 - BASE] = word;
        rd(io(700), word, "t5_stur_ldur");
        wr({8'h03, 56'd700}, ~word);
        rd(io(700), word, "t5_nonhit_write");
        rd({8'h03, 56'd700}, 64'h0, "t5_nonhit_read");

        // Reset in the middle of a frame, then restart from entry 0.
        link_up = 1'b1;
        ready_mode = 0;
        base = accepted;
        push_frame();
        wr(io(0), 64'h1);
        wait_beats(base + 100, 500, "t6_wait100");
        reset = 1'b1;
        ready_mode = 3;
        pix_ready = 1'b0;
        sb.delete();
        tick();
        check64("t6_valid_after_reset", {63'd0, pix_valid}, 64'd0);
        rd(io(2), 64'h3, "t6_status");
        rd(io(3), 64'h0, "t6_frames");
        reset = 1'b0;
        tick();
        ready_mode = 2;
        base = accepted;
        push_frame();
        wr(io(0), 64'h1);
        wait_drain("t6_drain", 4000);
        check64("t6_beats", 64'(accepted - base), 64'd600);
        rd(io(3), 64'h1, "t6_frames_final");
        rd(io(2), 64'h7, "t6_status_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
